// File: rtl/cpu_regfile_mp.sv
// cpu_regfile_mp: multi-port register file with write->read bypass, x0 hardwire and a sequential clear engine
module cpu_regfile_mp #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NREAD   = 2,
  parameter int NWRITE  = 1,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  output logic                    ready_o,
  input  logic [NREAD*AW-1:0]     raddr_i,
  output logic [NREAD*XLEN-1:0]   rdata_o,
  input  logic [NWRITE-1:0]       we_i,
  input  logic [NWRITE*AW-1:0]    waddr_i,
  input  logic [NWRITE*XLEN-1:0]  wdata_i
);
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;
  localparam logic [AW:0] LAST = (AW+1)'(NREGS-1);
  state_t state, state_nx;
  logic [AW:0] cnt, cnt_nx;
  logic [XLEN-1:0] regs [NREGS];
  function automatic logic legal(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(NREGS)) && !(ZERO_R0 != 0 && a == '0);
  endfunction
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
  // a clear request while already clearing restarts the sweep from entry 0
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == CLEAR) begin
      cnt_nx   = clear_i ? '0 : cnt + 1'b1;
      state_nx = (!clear_i && cnt == LAST) ? RUN : CLEAR;
    end else if (clear_i) begin
      state_nx = CLEAR;
      cnt_nx   = '0;
    end
  end
  assign ready_o = (state == RUN);
  // later ports overwrite earlier ones, so the highest-indexed port wins a conflict
  always_ff @(posedge clk_i) begin
    if (state == CLEAR)
      regs[cnt[AW-1:0]] <= '0;
    else
      for (int p = 0; p < NWRITE; p++)
        if (we_i[p] && legal(waddr_i[p*AW +: AW]))
          regs[waddr_i[p*AW +: AW]] <= wdata_i[p*XLEN +: XLEN];
  end
  for (genvar r = 0; r < NREAD; r++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] v;
    assign ra = raddr_i[r*AW +: AW];
    always_comb begin
      v = regs[ra];
      for (int q = 0; q < NWRITE; q++)
        if (BYPASS != 0 && we_i[q] && waddr_i[q*AW +: AW] == ra)
          v = wdata_i[q*XLEN +: XLEN];
    end
    assign rdata_o[r*XLEN +: XLEN] = (ready_o && legal(ra)) ? v : '0;
  end
endmodule

// File: tb/tb_cpu_regfile_mp.sv
// tb_cpu_regfile_mp: directed and random checks of two register-file configurations against an array model
module tb_cpu_regfile_mp;
  logic        clk_i = 1'b0, rst_i = 1'b1, clear_i = 1'b0;
  logic [9:0]  raddr_i = '0, waddr_i = '0;
  logic [1:0]  we_i = '0;
  logic [63:0] wdata_i = '0;
  logic [63:0] rd0, rd1;
  logic        rdy0, rdy1;
  int          n_cmp = 0, n_bad = 0, left = 32;
  logic [31:0] mem [2][32];

  always #5 clk_i = ~clk_i;

  cpu_regfile_mp #(.NREAD(2), .NWRITE(2), .BYPASS(1), .ZERO_R0(1)) u0 (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .ready_o(rdy0), .raddr_i(raddr_i),
    .rdata_o(rd0), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i));
  cpu_regfile_mp #(.NREAD(2), .NWRITE(2), .BYPASS(0), .ZERO_R0(0)) u1 (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .ready_o(rdy1), .raddr_i(raddr_i),
    .rdata_o(rd1), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // instance 0: bypass + x0 hardwire; instance 1: no bypass, r0 writable
  function automatic logic [31:0] exp_rd(input int i, input int a);
    logic [31:0] v;
    if (rst_i || left > 0 || (i == 0 && a == 0)) return '0;
    v = mem[i][a];
    if (i == 0)
      for (int p = 0; p < 2; p++)
        if (we_i[p] && int'(waddr_i[p*5 +: 5]) == a) v = wdata_i[p*32 +: 32];
    return v;
  endfunction

  task automatic zero_mem();
    for (int i = 0; i < 2; i++) for (int a = 0; a < 32; a++) mem[i][a] = '0;
  endtask

  task automatic tick();
    #1;
    chk("ready0", {31'b0, rdy0}, 32'(left == 0 && !rst_i));
    chk("ready1", {31'b0, rdy1}, 32'(left == 0 && !rst_i));
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rd0_p%0d_a%0d", p, raddr_i[p*5 +: 5]), rd0[p*32 +: 32], exp_rd(0, int'(raddr_i[p*5 +: 5])));
      chk($sformatf("rd1_p%0d_a%0d", p, raddr_i[p*5 +: 5]), rd1[p*32 +: 32], exp_rd(1, int'(raddr_i[p*5 +: 5])));
    end
    @(posedge clk_i);
    if (rst_i) begin
      left = 32;
      zero_mem();
    end else if (left > 0) begin
      left = clear_i ? 32 : left - 1;
    end else begin
      for (int p = 0; p < 2; p++)
        if (we_i[p]) begin
          if (waddr_i[p*5 +: 5] != 0) mem[0][waddr_i[p*5 +: 5]] = wdata_i[p*32 +: 32];
          mem[1][waddr_i[p*5 +: 5]] = wdata_i[p*32 +: 32];
        end
      if (clear_i) begin
        left = 32;
        zero_mem();
      end
    end
    @(negedge clk_i);
  endtask

  task automatic rnd_in();
    we_i    = 2'($urandom);
    waddr_i = 10'($urandom);
    wdata_i = {$urandom, $urandom};
    raddr_i = 10'($urandom);
    if ($urandom_range(0, 1) == 1) raddr_i[4:0] = waddr_i[9:5];
  endtask

  initial begin
    zero_mem();
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
    repeat (32) begin rnd_in(); tick(); end
    we_i = '0;
    for (int a = 0; a < 32; a++) begin raddr_i = {5'(31 - a), 5'(a)}; tick(); end
    we_i = 2'b11; waddr_i = {5'd5, 5'd5}; wdata_i = {32'hBBBB_0002, 32'hAAAA_0001}; raddr_i = {5'd5, 5'd5};
    tick();
    we_i = '0; tick();
    chk("dual_write_r5", rd1[31:0], 32'hBBBB_0002);
    we_i = 2'b01; waddr_i = {5'd0, 5'd7}; wdata_i = {32'h0, 32'h1234_5678}; raddr_i = {5'd0, 5'd7};
    tick();
    we_i = '0; tick();
    we_i = 2'b10; waddr_i = {5'd0, 5'd0}; wdata_i = {32'hFFFF_FFFF, 32'h0}; raddr_i = {5'd0, 5'd0};
    tick();
    we_i = '0; tick();
    for (int a = 1; a < 32; a++) begin
      we_i = 2'b01; waddr_i = {5'd0, 5'(a)}; wdata_i = {32'h0, $urandom | 32'h1};
      raddr_i = 10'($urandom);
      tick();
    end
    we_i = '0; clear_i = 1'b1; tick();
    clear_i = 1'b0;
    repeat (32) begin rnd_in(); tick(); end
    we_i = '0;
    for (int a = 0; a < 32; a++) begin raddr_i = {5'(a), 5'(31 - a)}; tick(); end
    clear_i = 1'b1; tick();
    clear_i = 1'b0;
    repeat (10) begin rnd_in(); tick(); end
    rst_i = 1'b1;
    repeat (2) begin rnd_in(); tick(); end
    rst_i = 1'b0;
    repeat (34) begin rnd_in(); tick(); end
    repeat (400) begin
      rnd_in();
      clear_i = ($urandom_range(0, 49) == 0);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
